// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on each side, registered flags that
// chain carry/borrow across ops, and a multi-cycle shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             c,
  output logic             z,
  output logic             n,
  output logic             v
);
  localparam int M = WIDTH - 1;

  localparam logic [3:0] OP_PASS = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3,
                         OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6,
                         OP_NOT  = 4'h7, OP_ADC = 4'h8, OP_SBB = 4'h9,
                         OP_SHL  = 4'hA, OP_SHR = 4'hB, OP_MUL = 4'hC,
                         OP_CMP  = 4'hD;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t             state, state_nx;
  logic [2*WIDTH-1:0] acc, mcand, prod;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               mul_last;
  logic [WIDTH:0]     res;
  logic               res_v, keep_o;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign mul_last  = (cnt == CNT_W'(WIDTH - 1));
  assign prod      = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = (op == OP_MUL) ? MUL : DONE;
      MUL:     if (mul_last) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Single-cycle ops; bit WIDTH of res is the carry (or borrow for subtracts).
  always_comb begin
    res    = '0;
    res_v  = 1'b0;
    keep_o = 1'b0;
    case (op)
      OP_PASS: res = {1'b0, B};
      OP_ADD, OP_ADC: begin
        res   = {1'b0, A} + {1'b0, B} + ((op == OP_ADC) ? (WIDTH+1)'(c) : '0);
        res_v = (A[M] == B[M]) && (res[M] != A[M]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        res    = {1'b0, A} - {1'b0, B} - ((op == OP_SBB) ? (WIDTH+1)'(c) : '0);
        res_v  = (A[M] != B[M]) && (res[M] != A[M]);
        keep_o = (op == OP_CMP);
      end
      OP_AND:  res = {1'b0, A & B};
      OP_OR:   res = {1'b0, A | B};
      OP_XOR:  res = {1'b0, A ^ B};
      OP_NOT:  res = {1'b0, ~A};
      OP_SHL:  res = {A, 1'b0};
      OP_SHR:  res = {A[0], 1'b0, A[M:1]};
      default: res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      O      <= '0;
      c      <= 1'b0;
      z      <= 1'b1;
      n      <= 1'b0;
      v      <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (op == OP_MUL) begin
            acc    <= '0;
            cnt    <= '0;
            mcand  <= {{WIDTH{1'b0}}, A};
            mplier <= B;
          end else begin
            if (!keep_o) O <= res[M:0];
            c <= res[WIDTH];
            z <= (res[M:0] == '0);
            n <= res[M];
            v <= res_v;
          end
        end
        MUL: begin
          acc    <= prod;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (mul_last) begin
            O <= prod[M:0];
            c <= |prod[2*WIDTH-1:WIDTH];
            z <= (prod[M:0] == '0);
            n <= prod[M];
            v <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: the driver queues hand-computed results, a
// monitor pops and compares them whenever a result is handed off.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]   op = '0;
  logic [W-1:0] A = '0, B = '0;
  logic         in_ready, out_valid, c, z, n, v;
  logic [W-1:0] O;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
    .O(O), .c(c), .z(z), .n(n), .v(v)
  );

  typedef struct packed {
    logic [15:0]  id;
    logic [W-1:0] o;
    logic [3:0]   czvn;  // {c,z,n,v}
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0, n_miss = 0, vid = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // Monitor: a result is consumed on the posedge after a negedge with both valid and ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected result: O=%h czvn=%b", O, {c, z, n, v});
        end else begin
          e = exp_q.pop_front();
          if ({O, c, z, n, v} !== {e.o, e.czvn}) begin
            n_miss++;
            $display("FAIL result #%0d: got O=%h czvn=%b, want O=%h czvn=%b",
                     e.id, O, {c, z, n, v}, e.o, e.czvn);
          end
        end
      end
    end
  end

  task automatic issue(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eo, input logic [3:0] eflags, input int lat);
    exp_t e;
    int   t;
    e.id = vid[15:0]; e.o = eo; e.czvn = eflags;
    vid++;
    exp_q.push_back(e);
    @(posedge clk); #1;
    op = o; A = a; B = b; in_valid = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 50);
    if (!in_ready) chk("accept timeout", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!out_valid && t < 50);
    chk("latency", 32'(t), 32'(lat));
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
    if (exp_q.size() != 0) begin
      chk("drain timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
  endtask

  task automatic run(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eo, input logic [3:0] eflags, input int lat);
    issue(o, a, b, eo, eflags, lat);
    drain();
  endtask

  initial begin
    #200000;
    n_miss++;
    $display("FAIL watchdog timeout");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 32'(0));
    chk("reset O", 32'(O), 32'(0));
    chk("reset czvn", 32'({c, z, n, v}), 32'(4'b0100));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", 32'(in_ready), 32'(1));

    //  op    A      B      O      czvn     lat
    run(4'h2, 8'hF0, 8'h20, 8'h10, 4'b1000, 1);  // ADD carry out
    run(4'h8, 8'h01, 8'h00, 8'h02, 4'b0000, 1);  // ADC cin=1
    run(4'h3, 8'h80, 8'h01, 8'h7F, 4'b0001, 1);  // SUB signed overflow
    run(4'h3, 8'h00, 8'h01, 8'hFF, 4'b1010, 1);  // SUB borrow
    run(4'hC, 8'h10, 8'h11, 8'h10, 4'b1000, 9);  // MUL high half nonzero
    run(4'hC, 8'h0F, 8'h0F, 8'hE1, 4'b0010, 9);  // MUL fits
    run(4'hD, 8'h05, 8'h05, 8'hE1, 4'b0100, 1);  // CMP keeps O
    run(4'h3, 8'h03, 8'h05, 8'hFE, 4'b1010, 1);  // SUB borrow
    run(4'h9, 8'h10, 8'h01, 8'h0E, 4'b0000, 1);  // SBB cin=1
    run(4'hA, 8'h81, 8'h00, 8'h02, 4'b1000, 1);  // SHL
    run(4'hB, 8'h01, 8'h00, 8'h00, 4'b1100, 1);  // SHR to zero
    run(4'h4, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1);  // AND
    run(4'h6, 8'hAA, 8'hAA, 8'h00, 4'b0100, 1);  // XOR
    run(4'h1, 8'h00, 8'h80, 8'h80, 4'b0010, 1);  // PASS
    run(4'h2, 8'h7F, 8'h01, 8'h80, 4'b0011, 1);  // ADD signed overflow
    run(4'h0, 8'hFF, 8'hFF, 8'h00, 4'b0100, 1);  // ZERO
    run(4'hE, 8'hFF, 8'hFF, 8'h00, 4'b0100, 1);  // reserved
    run(4'h8, 8'hFF, 8'h00, 8'hFF, 4'b0010, 1);  // ADC cin=0

    // Backpressure: result must hold and a pending op must be ignored.
    @(posedge clk); #1 out_ready = 1'b0;
    issue(4'h5, 8'h0F, 8'h30, 8'h3F, 4'b0000, 1);
    @(posedge clk); #1;
    op = 4'h2; A = 8'h01; B = 8'h01; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall O", 32'(O), 32'(8'h3F));
      chk("stall flags", 32'({c, z, n, v}), 32'(0));
      chk("stall out_valid", 32'(out_valid), 32'(1));
      chk("stall in_ready", 32'(in_ready), 32'(0));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("in_ready after release", 32'(in_ready), 32'(1));
    chk("out_valid after release", 32'(out_valid), 32'(0));
    drain();

    // Reset during the third MUL cycle aborts with no result.
    @(posedge clk); #1;
    op = 4'hC; A = 8'h10; B = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("aborted MUL out_valid", 32'(seen), 32'(0));
    chk("abort in_ready", 32'(in_ready), 32'(1));
    chk("abort O", 32'(O), 32'(0));
    chk("abort czvn", 32'({c, z, n, v}), 32'(4'b0100));
    run(4'h7, 8'h0F, 8'h00, 8'hF0, 4'b0010, 1);  // NOT after abort

    repeat (3) @(negedge clk);
    chk("leftover expectations", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the combinational 8-bit ALU.
- Width is set by parameter. Adds carry-chained ops (ADC/SBB), shifts, compare, and a multi-cycle shift-add multiply.
- Flags (c, z, n, v) are held in a register, so multi-word arithmetic can chain across operations.
- Sits between the control unit and the register file. Control issues ops over a valid/ready pair; results return over a second valid/ready pair.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, 4, multiply counter width; must satisfy 2^CNT_W > WIDTH

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  op/operands valid
in_ready  out  1  block can accept an op
op  in  4  operation code
A  in  WIDTH  operand A
B  in  WIDTH  operand B
out_valid  out  1  result/flags valid
out_ready  in  1  consumer takes result
O  out  WIDTH  registered result
c  out  1  carry/borrow flag (registered)
z  out  1  zero flag: O==0 (registered)
n  out  1  negative flag: O[WIDTH-1]
v  out  1  signed overflow flag

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: O=0, c=0, z=1, n=0, v=0, out_valid=0, state=IDLE. in_ready=1 in the cycle after reset.
- rst_n low mid-operation (including during MUL) aborts the op; no result is emitted.
- State machine: IDLE, MUL, DONE.
  - in_ready = (state==IDLE). in_valid is ignored outside IDLE.
  - IDLE with in_valid: op latched, plus A, B, and the current c as cin.
    - Single-cycle op: result and flags written; go to DONE; out_valid=1 on the next cycle (latency 1).
    - MUL: go to MUL with accumulator=0 and counter=0.
  - MUL: one shift-add step per cycle for WIDTH cycles, then DONE (latency WIDTH+1).
  - DONE: out_valid=1; O and flags held stable until out_ready=1, then IDLE.
  - in_ready rises the cycle after the handshake, so peak throughput is one op per 2 cycles.
- Arithmetic uses a WIDTH+1 internal result; c = bit WIDTH unless stated otherwise.
  - 0 ZERO: O=0, c=0.
  - 1 PASS: O=B, c=0.
  - 2 ADD: A+B.
  - 3 SUB: A-B; c=1 on borrow (A<B unsigned).
  - 4 AND, 5 OR, 6 XOR: bitwise, c=0.
  - 7 NOT: bitwise ~A (not logical), c=0.
  - 8 ADC: A+B+cin.
  - 9 SBB: A-B-cin; c=1 on borrow.
  - A SHL: O=A<<1, c=A[WIDTH-1].
  - B SHR: logical, O=A>>1, c=A[0].
  - C MUL: unsigned; O=low WIDTH bits of A*B; c=1 if the high WIDTH bits are nonzero.
  - D CMP: computes A-B; flags updated as SUB; O keeps its previous value.
  - E, F: reserved; behave as ZERO.
- Flag rules:
  - v is computed for ADD/SUB/ADC/SBB/CMP (two's-complement overflow); v=0 for all other ops.
  - z and n derive from the new result. For CMP they derive from the A-B difference, not from O.
  - Flags update only on the cycle DONE is entered; they hold at all other times.
- Wrap-around: all results modulo 2^WIDTH; no saturation.
- out_ready held high while idle has no effect. out_ready and in_valid both high in DONE: the new op is not accepted that cycle.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> O=0, z=1, c=0, out_valid=0; in_ready=1 the cycle after release.
- ADD overflow, WIDTH=8: A=0xF0, B=0x20, op=2 -> out_valid next cycle, O=0x10, c=1, z=0, v=0. Then ADC A=0x01, B=0x00 -> O=0x02, c=0.
- SUB borrow/signed: A=0x80, B=0x01, op=3 -> O=0x7F, c=0, v=1, n=0. Then A=0x00, B=0x01 -> O=0xFF, c=1, n=1.
- MUL: A=0x10, B=0x11, op=C -> out_valid exactly 9 cycles after accept, O=0x10, c=1. A=0x0F, B=0x0F -> O=0xE1, c=0.
- Backpressure: hold out_ready=0 for 5 cycles after a result -> O and flags stable, in_ready=0, new in_valid ignored. Release -> in_ready=1 next cycle.
- Reset mid-MUL: assert rst_n=0 at MUL cycle 3 -> no out_valid, state IDLE; a subsequent NOT A=0x0F -> O=0xF0, c=0.
